// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             a_bit, b_bit, d_bit, br_nxt, last;
   logic [WIDTH-1:0] a_shift, b_shift, res_shift;

   // Operands shift right; each difference bit enters the result at the MSB,
   // so after WIDTH shifts the result register is fully assembled.
   generate
      if (WIDTH == 1) begin : g_w1
         assign a_shift   = 1'b0;
         assign b_shift   = 1'b0;
         assign res_shift = d_bit;
      end else begin : g_wn
         assign a_shift   = {1'b0, a_sh_q[WIDTH-1:1]};
         assign b_shift   = {1'b0, b_sh_q[WIDTH-1:1]};
         assign res_shift = {d_bit, res_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      a_bit  = a_sh_q[0];
      b_bit  = b_sh_q[0];
      d_bit  = a_bit ^ b_bit ^ br_q;
      br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
      last   = (cnt_q == CW'(WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               res_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = a_shift;
            b_sh_d = b_shift;
            res_d  = res_shift;
            br_d   = br_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
               diff_d  = res_shift;
               bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
               // At the last step a_bit/b_bit/d_bit are the operand and result MSBs.
               ovf_d   = (a_bit != b_bit) && (d_bit != a_bit);
`endif
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 scenarios plus a WIDTH=4 exhaustive sweep.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, bout;
   logic [7:0] diff;
   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf, ovf4;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf(ovf),
`endif
      .bout(bout)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4),
`ifdef SERIAL_SUB_OVF_EN
      .ovf(ovf4),
`endif
      .bout(bout4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full WIDTH=8 operation with latency, busy-length and single-pulse checks.
   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
      int unsigned nbusy;
      int unsigned k;
      logic        seen;
      a = ta; b = tb_; start = 1'b1;
      tick();
      start = 1'b0;
      nbusy = 0; k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
         if (busy) nbusy++;
         tick();
         k++;
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, k, 32'd8);
      check({tag, "_busy_cycles"}, nbusy, 32'd8);
      check({tag, "_diff"}, 32'(diff), 32'(exp_d));
      check({tag, "_bout"}, 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
`else
      if (exp_o) begin end
`endif
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int unsigned ndone;
      int unsigned k;
      logic        seen;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      tick();
      tick();

      run8("t1", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
      run8("t2", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);

      // Reset during RUN: outputs clear at once and the aborted op never completes.
      a = 8'h11; b = 8'h22; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("t5_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_diff", 32'(diff), 32'd0);
      check("t5_bout", 32'(bout), 32'd0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) ndone++;
      end
      check("t5_no_done", ndone, 32'd0);
      run8("t5_after", 8'h20, 8'h0A, 8'h16, 1'b0, 1'b0);

      run8("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run8("t3b", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      // start held high through RUN/DONE with operands changed after E0.
      a = 8'h10; b = 8'h01; start = 1'b1;
      tick();
      a = 8'hFF; b = 8'hFF;
      ndone = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (done) ndone++;
         if (i == 7) begin
            check("t4_diff", 32'(diff), 32'h0F);
            check("t4_bout", 32'(bout), 32'd0);
         end
      end
      check("t4_one_done", ndone, 32'd1);
      check("t4_idle", 32'(busy), 32'd0);
      tick();
      check("t4_restart", 32'(busy), 32'd1);
      start = 1'b0;
      seen = 1'b0; k = 0;
      while (!seen && k < 20) begin
         tick();
         k++;
         if (done) seen = 1'b1;
      end
      check("t4_second_done", 32'(seen), 32'd1);
      check("t4_second_diff", 32'(diff), 32'h00);

      // Exhaustive WIDTH=4 sweep.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            logic [3:0] ea, eb;
            ea = 4'(ia); eb = 4'(ib);
            a4 = ea; b4 = eb; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            seen = 1'b0; k = 0;
            while (!seen && k < 10) begin
               tick();
               k++;
               if (done4) seen = 1'b1;
            end
            if (!seen) check("w4_timeout", 32'd0, 32'd1);
            check($sformatf("w4_diff_%0d_%0d", ia, ib), 32'(diff4), 32'((ea - eb) & 4'hF));
            check($sformatf("w4_bout_%0d_%0d", ia, ib), 32'(bout4), 32'(ia < ib));
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
